// File: rtl/key_scan_pkg.sv
// Shared definitions for the push-button front end: channel state encoding and
// the counter sizing helper used by the top and every channel.
package key_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } key_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One spare bit above the largest terminal count so the saturating
    // counter in HELD can never alias onto a compare value.
    function automatic int cnt_width(input int deb, input int hold, input int rep);
        return $clog2(max3(deb, hold, rep)) + 1;
    endfunction

endpackage

// File: rtl/key_scan_ch.sv
// One key channel: 2-flop synchroniser, debounce/hold/repeat FSM with a shared
// counter, and registered press-pulse and debounced-level outputs.
//
//   state         | meaning
//   ST_IDLE       | key released and accepted as released
//   ST_PRESS_DB   | press seen, counting stable-pressed cycles
//   ST_HELD       | press accepted, level high, timing hold/repeat pulses
//   ST_RELEASE_DB | release seen, counting stable-released cycles
module key_scan_ch
    import key_scan_pkg::*;
#(
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int HOLD_CYCLES     = 5000,
    parameter int REPEAT_CYCLES   = 1000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int CNT_W           = 14
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key,
    output logic o_status,
    output logic o_level
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_rep;
    logic             w_rep_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_status;
    logic             w_pulse;
    logic             w_pressed;

    assign w_pressed = r_sync2 ^ KEY_ACTIVE_LOW;
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Synchronisers come out of reset at the released pin level so a
    // key held through reset is re-debounced from scratch.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1  <= KEY_ACTIVE_LOW;
            r_sync2  <= KEY_ACTIVE_LOW;
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rep    <= 1'b0;
            r_level  <= 1'b0;
            r_status <= 1'b0;
        end else begin
            r_sync1  <= i_key;
            r_sync2  <= r_sync1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rep    <= w_rep_nxt;
            r_level  <= w_level_nxt;
            r_status <= w_pulse;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rep_nxt   = r_rep;
        w_level_nxt = r_level;
        w_pulse     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pressed) begin
                    w_state_nxt = ST_PRESS_DB;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_rep_nxt   = 1'b0;
                    w_pulse     = 1'b1;
                    w_level_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_HELD: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_RELEASE_DB;
                    w_cnt_nxt   = '0;
                end else if (REPEAT_EN && !r_rep && (r_cnt == HOLD_LAST)) begin
                    w_pulse   = 1'b1;
                    w_cnt_nxt = '0;
                    w_rep_nxt = 1'b1;
                end else if (REPEAT_EN && r_rep && (r_cnt == REP_LAST)) begin
                    w_pulse   = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_RELEASE_DB: begin
                // A bounce back to pressed resumes HELD silently and restarts the hold delay.
                if (w_pressed) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_rep_nxt   = 1'b0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_status = r_status;
    assign o_level  = r_level;

endmodule

// File: rtl/key_scan.sv
// Push-button front end: one independent debounce/repeat channel per key,
// with the per-key repeat enable fanned out as a channel parameter.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int                N_KEYS          = 3,
    parameter bit                KEY_ACTIVE_LOW  = 1'b1,
    parameter int                DEBOUNCE_CYCLES = 20,
    parameter int                HOLD_CYCLES     = 5000,
    parameter int                REPEAT_CYCLES   = 1000,
    parameter logic [N_KEYS-1:0] REPEAT_EN       = 3'b011
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_status,
    output logic [N_KEYS-1:0] key_level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    genvar g;
    generate
        for (g = 0; g < N_KEYS; g++) begin : g_ch
            key_scan_ch #(
                .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .HOLD_CYCLES     (HOLD_CYCLES),
                .REPEAT_CYCLES   (REPEAT_CYCLES),
                .REPEAT_EN       (REPEAT_EN[g]),
                .CNT_W           (CNT_W)
            ) u_ch (
                .i_clk    (clk),
                .i_reset  (reset),
                .i_key    (key_in[g]),
                .o_status (key_status[g]),
                .o_level  (key_level[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: expected pulses are queued with their edge number when a key
// is driven; a negedge monitor pops and compares them as key_status fires.
module tb_key_scan;

    localparam int N   = 3;
    localparam int DEB = 4;
    localparam int HLD = 10;
    localparam int REP = 3;
    localparam int LAT = DEB + 3;   // drive at negedge c -> pulse after edge c+LAT

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] key_in;
    logic [N-1:0] key_status;
    logic [N-1:0] key_level;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int           edge_no;
        logic [N-1:0] mask;
    } exp_t;
    exp_t sb[$];

    key_scan #(
        .N_KEYS          (N),
        .KEY_ACTIVE_LOW  (1'b1),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HLD),
        .REPEAT_CYCLES   (REP),
        .REPEAT_EN       (3'b011)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_status (key_status),
        .key_level  (key_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", tag, obs, want, cyc);
        end
    endtask

    task automatic wait_cyc(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic expect_pulse(input int e, input logic [N-1:0] m);
        exp_t x;
        x.edge_no = e;
        x.mask    = m;
        sb.push_back(x);
    endtask

    // Monitor: every pulse must match the queue head at its edge; anything else is spurious.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].edge_no == cyc) begin
                chk("pulse", 32'(key_status), 32'(sb[0].mask));
                void'(sb.pop_front());
            end else if (key_status != '0) begin
                chk("spurious_pulse", 32'(key_status), 32'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int c;
        int r;
        int h;
        int d;

        reset  = 1'b1;
        key_in = '1;
        repeat (3) @(negedge clk);
        chk("rst_status", 32'(key_status), 32'(0));
        chk("rst_level", 32'(key_level), 32'(0));
        reset = 1'b0;
        wait_cyc(cyc + 3);

        // 1: clean press on key 0, level timing, no pulse on release
        c = cyc;
        key_in[0] = 1'b0;
        expect_pulse(c + LAT, 3'b001);
        wait_cyc(c + LAT - 1);
        chk("t1_level_pre", 32'(key_level[0]), 32'(0));
        wait_cyc(c + LAT);
        chk("t1_level_on", 32'(key_level[0]), 32'(1));
        wait_cyc(c + 8);
        key_in[0] = 1'b1;
        r = cyc;
        wait_cyc(r + LAT - 1);
        chk("t1_level_hold", 32'(key_level[0]), 32'(1));
        wait_cyc(r + LAT);
        chk("t1_level_off", 32'(key_level[0]), 32'(0));
        wait_cyc(r + 15);

        // 2: bounce on key 1, 3 low / 1 high / 3 low
        c = cyc;
        key_in[1] = 1'b0;
        wait_cyc(c + 3); key_in[1] = 1'b1;
        wait_cyc(c + 4); key_in[1] = 1'b0;
        wait_cyc(c + 7); key_in[1] = 1'b1;
        wait_cyc(c + 9);
        chk("t2_level_mid", 32'(key_level[1]), 32'(0));
        wait_cyc(c + 20);
        chk("t2_level_end", 32'(key_level), 32'(0));

        // 3a: hold-to-repeat on key 0 for 40 cycles
        c = cyc;
        key_in[0] = 1'b0;
        expect_pulse(c + LAT, 3'b001);
        for (int k = 0; c + LAT + HLD + REP * k <= c + 40 + 2; k++)
            expect_pulse(c + LAT + HLD + REP * k, 3'b001);
        wait_cyc(c + 40);
        key_in[0] = 1'b1;
        wait_cyc(c + 55);
        chk("t3_rep_drained", 32'(sb.size()), 32'(0));
        chk("t3_rep_level", 32'(key_level[0]), 32'(0));

        // 3b: key 2 has repeat disabled -> exactly one pulse
        c = cyc;
        key_in[2] = 1'b0;
        expect_pulse(c + LAT, 3'b100);
        wait_cyc(c + 30);
        chk("t3_norep_level", 32'(key_level[2]), 32'(1));
        wait_cyc(c + 40);
        key_in[2] = 1'b1;
        wait_cyc(c + 55);
        chk("t3_norep_drained", 32'(sb.size()), 32'(0));

        // 4: release bounce while HELD restarts the hold delay
        c = cyc;
        key_in[0] = 1'b0;
        expect_pulse(c + LAT, 3'b001);
        h = c + 12;
        wait_cyc(h);
        key_in[0] = 1'b1;
        wait_cyc(h + 2);
        key_in[0] = 1'b0;
        wait_cyc(h + 4);
        chk("t4_level_rdb", 32'(key_level[0]), 32'(1));
        wait_cyc(h + 5);
        chk("t4_level_back", 32'(key_level[0]), 32'(1));
        expect_pulse(h + 5 + HLD, 3'b001);
        expect_pulse(h + 5 + HLD + REP, 3'b001);
        expect_pulse(h + 5 + HLD + 2 * REP, 3'b001);
        wait_cyc(h + 20);
        key_in[0] = 1'b1;
        r = cyc;
        wait_cyc(r + LAT);
        chk("t4_level_off", 32'(key_level[0]), 32'(0));
        wait_cyc(r + 12);
        chk("t4_drained", 32'(sb.size()), 32'(0));

        // 5: simultaneous press of keys 0 and 1
        c = cyc;
        key_in[1:0] = 2'b00;
        expect_pulse(c + LAT, 3'b011);
        wait_cyc(c + LAT);
        chk("t5_level", 32'(key_level), 32'(3'b011));
        wait_cyc(c + 8);
        key_in[1:0] = 2'b11;
        wait_cyc(c + 25);
        chk("t5_level_off", 32'(key_level), 32'(0));

        // 6a: reset mid-PRESS_DB with key held through reset release
        c = cyc;
        key_in[0] = 1'b0;
        wait_cyc(c + 4);
        reset = 1'b1;
        #1;
        chk("t6a_rst_level", 32'(key_level), 32'(0));
        wait_cyc(c + 6);
        reset = 1'b0;
        d = cyc;
        expect_pulse(d + LAT, 3'b001);
        wait_cyc(d + LAT - 1);
        chk("t6a_level_pre", 32'(key_level[0]), 32'(0));
        wait_cyc(d + LAT);
        chk("t6a_level_on", 32'(key_level[0]), 32'(1));
        wait_cyc(d + 10);
        key_in[0] = 1'b1;
        wait_cyc(d + 22);

        // 6b: reset in the pulse cycle of a HELD key clears outputs asynchronously
        c = cyc;
        key_in[2] = 1'b0;
        expect_pulse(c + LAT, 3'b100);
        wait_cyc(c + LAT);
        #1;
        chk("t6b_level_before", 32'(key_level[2]), 32'(1));
        reset = 1'b1;
        #1;
        chk("t6b_rst_status", 32'(key_status), 32'(0));
        chk("t6b_rst_level", 32'(key_level), 32'(0));
        key_in[2] = 1'b1;
        wait_cyc(c + LAT + 2);
        reset = 1'b0;
        wait_cyc(c + LAT + 20);
        chk("t6b_level_after", 32'(key_level), 32'(0));

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
